// File: rtl/regfile_loader_if.sv
// Handshake and register-file bus between the byte-stream feeder, the loader
// and the downstream scanner. master = environment side, slave = loader.
interface regfile_loader_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          W_en;
  logic [AW-1:0] W_Addr;
  logic [DW-1:0] W_Data;
  logic          go;
  logic          done;
  logic          busy;
  logic          complete;
  logic          timeout_err;
  logic [AW:0]   count;

  modport master (
    output start, in_valid, in_data, done,
    input  in_ready, W_en, W_Addr, W_Data, go, busy, complete, timeout_err, count
  );

  modport slave (
    input  start, in_valid, in_data, done,
    output in_ready, W_en, W_Addr, W_Data, go, busy, complete, timeout_err, count
  );
endinterface

// File: rtl/regfile_loader.sv
// Loads DEPTH bytes from a valid/ready stream into consecutive register-file
// addresses, kicks the scanner with a one-cycle go, then waits for done with
// an optional timeout. All outputs are registered except in_ready and busy.
module regfile_loader #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic           Clk,
  input  logic           Rst,
  regfile_loader_if.slave bus
);

  // Timer only needs to reach TIMEOUT-1; TIMEOUT=0 disables the check.
  localparam int          TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int          TLAST_I  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TW-1:0] TLAST  = TW'(TLAST_I);
  localparam logic [AW:0] LAST_CNT = (AW+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_GO, S_WAIT, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          go_q, go_d;
  logic          cmpl_q, cmpl_d;
  logic          terr_q, terr_d;
  logic          accept;

  // Next-state and registered-output logic; write/go/complete default low.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    go_d    = 1'b0;
    cmpl_d  = 1'b0;
    terr_d  = terr_q;
    accept  = (state_q == S_LOAD) && bus.in_valid;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
          count_d = '0;
          terr_d  = 1'b0;
        end
      end
      S_LOAD: begin
        // count < DEPTH here, so its low bits are the write address
        if (accept) begin
          wen_d   = 1'b1;
          waddr_d = count_q[AW-1:0];
          wdata_d = bus.in_data;
          count_d = count_q + (AW+1)'(1);
          if (count_q == LAST_CNT) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // last write is on the bus this cycle; go follows next cycle
        state_d = S_GO;
        go_d    = 1'b1;
      end
      S_GO: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (bus.done) begin
          state_d = S_FIN;
          cmpl_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
          if (TIMEOUT != 0 && timer_q == TLAST) begin
            terr_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; async reset aborts any frame in progress.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      timer_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      go_q    <= 1'b0;
      cmpl_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      timer_q <= timer_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      go_q    <= go_d;
      cmpl_q  <= cmpl_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.in_ready    = (state_q == S_LOAD);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.W_en        = wen_q;
  assign bus.W_Addr      = waddr_q;
  assign bus.W_Data      = wdata_q;
  assign bus.go          = go_q;
  assign bus.complete    = cmpl_q;
  assign bus.timeout_err = terr_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader: the driver pushes expected writes, go and
// complete events (with their cycle) into queues; a negedge monitor pops and
// compares whenever the DUT presents one.
module tb_regfile_loader;
  localparam int DEPTH = 16;
  localparam int TO    = 8;

  logic Clk, Rst;
  int   cyc;
  int   nchk, nerr;
  int   maddr;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic [4:0] cnt;
    int         c;
  } wr_t;

  wr_t wq[$];
  int  gq[$];
  int  cq[$];
  wr_t mon_e;
  int  mon_c;

  regfile_loader_if #(.AW(4), .DW(8)) bus ();

  regfile_loader #(.DEPTH(DEPTH), .AW(4), .DW(8), .TIMEOUT(TO)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  // Monitor: every presented write/go/complete must match the next expectation.
  always @(negedge Clk) begin
    if (Rst === 1'b1) begin
      if (bus.W_en === 1'b1) begin
        if (wq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.W_Addr, bus.W_Data);
        end else begin
          mon_e = wq.pop_front();
          chk("w_addr",  32'(bus.W_Addr), 32'(mon_e.addr));
          chk("w_data",  32'(bus.W_Data), 32'(mon_e.data));
          chk("w_count", 32'(bus.count),  32'(mon_e.cnt));
          chk("w_cycle", 32'(cyc),        32'(mon_e.c));
        end
      end
      if (bus.go === 1'b1) begin
        if (gq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_go: cycle %0d, none expected", cyc);
        end else begin
          mon_c = gq.pop_front();
          chk("go_cycle", 32'(cyc), 32'(mon_c));
        end
      end
      if (bus.complete === 1'b1) begin
        if (cq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_complete: cycle %0d, none expected", cyc);
        end else begin
          mon_c = cq.pop_front();
          chk("complete_cycle", 32'(cyc), 32'(mon_c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_W_en"},     32'(bus.W_en),        32'd0);
    chk({tag, "_W_Addr"},   32'(bus.W_Addr),      32'd0);
    chk({tag, "_W_Data"},   32'(bus.W_Data),      32'd0);
    chk({tag, "_go"},       32'(bus.go),          32'd0);
    chk({tag, "_complete"}, 32'(bus.complete),    32'd0);
    chk({tag, "_terr"},     32'(bus.timeout_err), 32'd0);
    chk({tag, "_count"},    32'(bus.count),       32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready),    32'd0);
    chk({tag, "_busy"},     32'(bus.busy),        32'd0);
  endtask

  task automatic do_start();
    tick();
    bus.start = 1'b1;
    maddr     = 0;
    tick();
    bus.start = 1'b0;
    chk("start_busy",  32'(bus.busy),        32'd1);
    chk("start_count", 32'(bus.count),       32'd0);
    chk("start_terr",  32'(bus.timeout_err), 32'd0);
  endtask

  // Sends bytes base, base+1, ...; gap inserts an idle cycle between bytes;
  // stop_after>0 ends early; start is pulsed on the cycle byte start_at goes.
  task automatic send_frame(input logic [7:0] base, input bit gap, input int stop_after,
                            input int start_at, output int last_c);
    int n, guard;
    bit ph;
    n = 0; guard = 0; ph = 1'b0; last_c = 0;
    while (n < DEPTH && guard < 100) begin
      tick();
      guard++;
      bus.start = (n == start_at);
      if (gap && ph) begin
        bus.in_valid = 1'b0;
        chk("gap_in_ready", 32'(bus.in_ready), 32'd1);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(base + 8'(n));
        chk("in_ready", 32'(bus.in_ready), 32'd1);
        if (bus.in_ready === 1'b1) begin
          wq.push_back('{4'(maddr), 8'(base + 8'(n)), 5'(maddr + 1), cyc + 1});
          maddr++;
          n++;
          last_c = cyc;
        end
      end
      ph = ~ph;
      if (stop_after != 0 && n == stop_after) break;
    end
    tick();
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (stop_after == 0) chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
  endtask

  // go is due 2 cycles after the last accept; done_dly<0 means never answer.
  task automatic finish_frame(input int last_c, input int done_dly);
    int g;
    g = last_c + 2;
    gq.push_back(g);
    if (done_dly >= 0) begin
      while (cyc < g + done_dly) tick();
      bus.done = 1'b1;
      cq.push_back(g + done_dly + 1);
      tick();
      bus.done = 1'b0;
      chk("fin_busy",  32'(bus.busy),  32'd1);
      chk("fin_count", 32'(bus.count), 32'(DEPTH));
      tick();
      chk("after_fin_busy", 32'(bus.busy), 32'd0);
    end else begin
      while (cyc < g + TO) tick();
      chk("to_last_terr", 32'(bus.timeout_err), 32'd0);
      chk("to_last_busy", 32'(bus.busy),        32'd1);
      tick();
      chk("to_terr", 32'(bus.timeout_err), 32'd1);
      chk("to_busy", 32'(bus.busy),        32'd0);
      tick();
      chk("to_terr_sticky", 32'(bus.timeout_err), 32'd1);
    end
  endtask

  initial begin
    int lc;
    nchk = 0; nerr = 0; maddr = 0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.done = 1'b0;
    Rst = 1'b0;
    repeat (3) tick();
    chk_reset("por");
    Rst = 1'b1;
    tick();

    // back-to-back frame, done 5 cycles after go
    do_start();
    send_frame(8'h00, 1'b0, 0, -1, lc);
    finish_frame(lc, 5);

    // one byte every other cycle; done raised during LOAD must be ignored
    bus.done = 1'b1;
    do_start();
    bus.done = 1'b0;
    send_frame(8'hA0, 1'b1, 0, -1, lc);
    finish_frame(lc, 2);

    // scanner never answers
    do_start();
    send_frame(8'h30, 1'b0, 0, -1, lc);
    finish_frame(lc, -1);

    // new start clears the error; stray start mid-load; async reset after byte 7
    do_start();
    send_frame(8'h50, 1'b0, 7, 3, lc);
    #5;
    Rst = 1'b0;
    #1;
    chk_reset("async");
    Rst = 1'b1;
    #1;
    do_start();
    send_frame(8'h60, 1'b0, 0, -1, lc);
    finish_frame(lc, 1);

    repeat (3) tick();
    chk("wq_empty", 32'(wq.size()), 32'd0);
    chk("gq_empty", 32'(gq.size()), 32'd0);
    chk("cq_empty", 32'(cq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit reached");
    $fatal(1, "watchdog");
  end
endmodule
